// File: rtl/mesi_isc_protocol_monitor_if.sv
// Bus bundle observed by the MESI ISC protocol monitor.
// master drives the main/coherence bus signals, slave samples them.
interface mesi_isc_protocol_monitor_if #(
    parameter int CPU_COUNT      = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int MBUS_CMD_WIDTH = 3,
    parameter int CBUS_CMD_WIDTH = 3
);
    logic [CPU_COUNT*MBUS_CMD_WIDTH-1:0] mbus_cmd_array_i;
    logic [CPU_COUNT*ADDR_WIDTH-1:0]     mbus_addr_array_i;
    logic [CPU_COUNT-1:0]                mbus_ack_array_i;
    logic [CPU_COUNT*CBUS_CMD_WIDTH-1:0] cbus_cmd_array_i;
    logic [CPU_COUNT-1:0]                cbus_ack_array_i;

    modport master (
        output mbus_cmd_array_i,
        output mbus_addr_array_i,
        output mbus_ack_array_i,
        output cbus_cmd_array_i,
        output cbus_ack_array_i
    );

    modport slave (
        input mbus_cmd_array_i,
        input mbus_addr_array_i,
        input mbus_ack_array_i,
        input cbus_cmd_array_i,
        input cbus_ack_array_i
    );
endinterface

// File: rtl/mesi_isc_protocol_monitor.sv
// Passive MESI ISC protocol monitor: per-CPU ack tracking, sticky error flags.
// Define MESI_ISC_MON_CAPTURE_EN to record the first error (cpu/code/addr).
module mesi_isc_protocol_monitor #(
    parameter int CPU_COUNT       = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int MBUS_CMD_WIDTH  = 3,
    parameter int CBUS_CMD_WIDTH  = 3,
    parameter int ACK_TIMEOUT     = 16,
    parameter int TIMEOUT_WIDTH   = 5,
    parameter int ERR_COUNT_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    mesi_isc_protocol_monitor_if.slave bus,
    input  logic                       clear_i,
    output logic [6:0]                 err_vec_o,
    output logic                       err_o,
    output logic [ERR_COUNT_WIDTH-1:0] err_count_o,
    output logic [CPU_COUNT-1:0]       pending_o,
    output logic [2:0]                 err_cpu_o,
    output logic [2:0]                 err_code_o,
    output logic [ADDR_WIDTH-1:0]      err_addr_o
);
    localparam logic [MBUS_CMD_WIDTH-1:0] MB_NOP = '0;
    localparam logic [MBUS_CMD_WIDTH-1:0] MB_WR  = MBUS_CMD_WIDTH'(1);
    localparam logic [MBUS_CMD_WIDTH-1:0] MB_MAX = MBUS_CMD_WIDTH'(4);
    localparam logic [CBUS_CMD_WIDTH-1:0] CB_EWR = CBUS_CMD_WIDTH'(3);
    localparam logic [CBUS_CMD_WIDTH-1:0] CB_ERD = CBUS_CMD_WIDTH'(4);
    localparam logic [CBUS_CMD_WIDTH-1:0] CB_MAX = CBUS_CMD_WIDTH'(4);
    localparam logic [TIMEOUT_WIDTH-1:0]  TO_VAL = TIMEOUT_WIDTH'(ACK_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_STALL = 2'd2
    } state_t;

    state_t                     r_state [CPU_COUNT];
    logic [TIMEOUT_WIDTH-1:0]   r_cnt   [CPU_COUNT];
    logic [CPU_COUNT-1:0]       r_prev_ack;
    logic [6:0]                 r_err_vec;
    logic                       r_err;
    logic [ERR_COUNT_WIDTH-1:0] r_err_cnt;

    logic [MBUS_CMD_WIDTH-1:0]  w_mcmd [CPU_COUNT];
    logic [ADDR_WIDTH-1:0]      w_addr [CPU_COUNT];
    logic [CBUS_CMD_WIDTH-1:0]  w_ccmd [CPU_COUNT];
    logic [CPU_COUNT-1:0]       w_ack;
    logic [CPU_COUNT-1:0]       w_en;
    logic [CPU_COUNT-1:0]       w_hit  [7];
    logic [6:0]                 w_new;
    logic                       w_unused_cbus_ack;

    // cbus acks carry no rule of their own; kept only for completeness
    assign w_unused_cbus_ack = ^bus.cbus_ack_array_i;

    for (genvar g = 0; g < CPU_COUNT; g++) begin : g_unpack
        assign w_mcmd[g] = bus.mbus_cmd_array_i[g*MBUS_CMD_WIDTH +: MBUS_CMD_WIDTH];
        assign w_addr[g] = bus.mbus_addr_array_i[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_ccmd[g] = bus.cbus_cmd_array_i[g*CBUS_CMD_WIDTH +: CBUS_CMD_WIDTH];
        assign w_ack[g]  = bus.mbus_ack_array_i[g];
        assign pending_o[g] = (r_state[g] != S_IDLE);
    end

    // per-code, per-CPU violation hits for the current cycle
    always_comb begin
        for (int c = 0; c < 7; c++) begin
            w_hit[c] = '0;
        end
        w_en = '0;
        for (int i = 0; i < CPU_COUNT; i++) begin
            w_hit[0][i] = (w_mcmd[i] > MB_MAX);
            w_hit[1][i] = (w_ccmd[i] > CB_MAX);
            w_hit[2][i] = w_ack[i] & r_prev_ack[i];
            w_hit[3][i] = (r_state[i] == S_WAIT) & ~w_ack[i] &
                          (r_cnt[i] == TO_VAL);
            w_hit[4][i] = (r_state[i] == S_IDLE) & w_ack[i] &
                          (w_mcmd[i] == MB_NOP);
            for (int j = 0; j < CPU_COUNT; j++) begin
                if ((j != i) && (w_mcmd[i] == MB_WR) &&
                    (w_mcmd[j] == MB_WR) && (w_addr[i] == w_addr[j])) begin
                    w_hit[5][i] = 1'b1;
                end
            end
            w_en[i] = (w_ccmd[i] == CB_EWR) | (w_ccmd[i] == CB_ERD);
        end
        // more than one bit set: clearing the lowest set bit leaves a 1
        if ((w_en & (w_en - 1'b1)) != '0) begin
            w_hit[6] = w_en;
        end
        for (int c = 0; c < 7; c++) begin
            w_new[c] = |w_hit[c];
        end
    end

    // per-CPU request/ack tracker; clear_i deliberately not involved
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < CPU_COUNT; i++) begin
                r_state[i] <= S_IDLE;
                r_cnt[i]   <= '0;
            end
            r_prev_ack <= '0;
        end else begin
            r_prev_ack <= w_ack;
            for (int i = 0; i < CPU_COUNT; i++) begin
                unique case (r_state[i])
                    S_IDLE: begin
                        if ((w_mcmd[i] != MB_NOP) && !w_ack[i]) begin
                            r_state[i] <= S_WAIT;
                            r_cnt[i]   <= TIMEOUT_WIDTH'(1);
                        end
                    end
                    S_WAIT: begin
                        if (w_ack[i]) begin
                            r_state[i] <= S_IDLE;
                            r_cnt[i]   <= '0;
                        end else if (r_cnt[i] == TO_VAL) begin
                            r_state[i] <= S_STALL;
                        end else begin
                            r_cnt[i] <= r_cnt[i] + TIMEOUT_WIDTH'(1);
                        end
                    end
                    S_STALL: begin
                        if (w_ack[i]) begin
                            r_state[i] <= S_IDLE;
                            r_cnt[i]   <= '0;
                        end
                    end
                    default: begin
                        r_state[i] <= S_IDLE;
                        r_cnt[i]   <= '0;
                    end
                endcase
            end
        end
    end

    // sticky flags, one-cycle pulse and saturating error-cycle count
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_err_vec <= '0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_err_vec <= (clear_i ? 7'd0 : r_err_vec) | w_new;
            r_err     <= |w_new;
            if (clear_i) begin
                r_err_cnt <= (|w_new) ? ERR_COUNT_WIDTH'(1) : '0;
            end else if ((|w_new) && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + ERR_COUNT_WIDTH'(1);
            end
        end
    end

    assign err_vec_o   = r_err_vec;
    assign err_o       = r_err;
    assign err_count_o = r_err_cnt;

`ifdef MESI_ISC_MON_CAPTURE_EN
    logic                  r_cap_valid;
    logic [2:0]            r_cap_cpu;
    logic [2:0]            r_cap_code;
    logic [ADDR_WIDTH-1:0] r_cap_addr;
    logic [2:0]            w_sel_cpu;
    logic [2:0]            w_sel_code;
    logic [ADDR_WIDTH-1:0] w_sel_addr;

    // pick lowest code, then lowest CPU; later matches override earlier ones
    always_comb begin
        w_sel_cpu  = '0;
        w_sel_code = '0;
        w_sel_addr = '0;
        for (int c = 6; c >= 0; c--) begin
            for (int i = CPU_COUNT - 1; i >= 0; i--) begin
                if (w_hit[c][i]) begin
                    w_sel_code = 3'(c);
                    w_sel_cpu  = 3'(i);
                    w_sel_addr = ((c == 1) || (c == 6)) ? '0 : w_addr[i];
                end
            end
        end
    end

    // hold first error until clear; a same-cycle error re-arms after clear
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cap_valid <= 1'b0;
            r_cap_cpu   <= '0;
            r_cap_code  <= '0;
            r_cap_addr  <= '0;
        end else if (clear_i || !r_cap_valid) begin
            r_cap_valid <= |w_new;
            r_cap_cpu   <= w_sel_cpu;
            r_cap_code  <= w_sel_code;
            r_cap_addr  <= w_sel_addr;
        end
    end

    assign err_cpu_o  = r_cap_cpu;
    assign err_code_o = r_cap_code;
    assign err_addr_o = r_cap_addr;
`else
    assign err_cpu_o  = '0;
    assign err_code_o = '0;
    assign err_addr_o = '0;
`endif
endmodule

// File: tb/tb_mesi_isc_protocol_monitor.sv
// Self-checking bench for mesi_isc_protocol_monitor: directed plan
// scenarios plus randomized traffic against a rule-level reference model.
module tb_mesi_isc_protocol_monitor;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int MW = 3;
    localparam int CW = 3;
    localparam int TO = 16;
    localparam int TW = 5;
    localparam int EW = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clear = 1'b0;

    logic [6:0]    err_vec;
    logic          err;
    logic [EW-1:0] err_count;
    logic [N-1:0]  pending;
    logic [2:0]    err_cpu;
    logic [2:0]    err_code;
    logic [AW-1:0] err_addr;

    int n_cmp = 0;
    int n_fail = 0;

    logic [2:0]    t_cmd  [N];
    logic [AW-1:0] t_addr [N];
    logic          t_ack  [N];
    logic [2:0]    t_ccmd [N];
    logic          t_cack [N];

    int            m_age  [N];
    bit            m_pack [N];
    logic [6:0]    m_vec;
    bit            m_pulse;
    int            m_cnt;
    bit            m_cv;
    int            m_ccpu;
    int            m_ccode;
    logic [AW-1:0] m_caddr;

    always #5 clk = ~clk;

    mesi_isc_protocol_monitor_if #(
        .CPU_COUNT(N), .ADDR_WIDTH(AW),
        .MBUS_CMD_WIDTH(MW), .CBUS_CMD_WIDTH(CW)
    ) bif ();

    mesi_isc_protocol_monitor #(
        .CPU_COUNT(N), .ADDR_WIDTH(AW), .MBUS_CMD_WIDTH(MW),
        .CBUS_CMD_WIDTH(CW), .ACK_TIMEOUT(TO), .TIMEOUT_WIDTH(TW),
        .ERR_COUNT_WIDTH(EW)
    ) dut (
        .clk(clk), .rst(rst), .bus(bif), .clear_i(clear),
        .err_vec_o(err_vec), .err_o(err), .err_count_o(err_count),
        .pending_o(pending), .err_cpu_o(err_cpu),
        .err_code_o(err_code), .err_addr_o(err_addr)
    );

    // Reference model: age = cycles since an unanswered request (0 = none);
    // the timeout fires exactly when a request has waited ACK_TIMEOUT edges.
    task automatic model_edge();
        bit   hit [7][N];
        logic [6:0] nw;
        int   nen;
        bit   found;
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                m_age[i] = 0;
                m_pack[i] = 0;
            end
            m_vec = 0; m_pulse = 0; m_cnt = 0;
            m_cv = 0; m_ccpu = 0; m_ccode = 0; m_caddr = 0;
            return;
        end
        nen = 0;
        for (int i = 0; i < N; i++) begin
            if (t_ccmd[i] == 3 || t_ccmd[i] == 4) nen++;
        end
        for (int i = 0; i < N; i++) begin
            hit[0][i] = t_cmd[i] > 4;
            hit[1][i] = t_ccmd[i] > 4;
            hit[2][i] = t_ack[i] && m_pack[i];
            hit[3][i] = (m_age[i] == TO) && !t_ack[i];
            hit[4][i] = t_ack[i] && (m_age[i] == 0) && (t_cmd[i] == 0);
            hit[5][i] = 0;
            for (int j = 0; j < N; j++) begin
                if (j != i && t_cmd[i] == 1 && t_cmd[j] == 1 &&
                    t_addr[i] == t_addr[j]) hit[5][i] = 1;
            end
            hit[6][i] = (nen >= 2) && (t_ccmd[i] == 3 || t_ccmd[i] == 4);
        end
        nw = 0;
        for (int c = 0; c < 7; c++) begin
            for (int i = 0; i < N; i++) if (hit[c][i]) nw[c] = 1;
        end
        for (int i = 0; i < N; i++) begin
            if (m_age[i] == 0) begin
                if (t_cmd[i] != 0 && !t_ack[i]) m_age[i] = 1;
            end else if (t_ack[i]) begin
                m_age[i] = 0;
            end else if (m_age[i] < 100000) begin
                m_age[i] = m_age[i] + 1;
            end
            m_pack[i] = t_ack[i];
        end
        m_vec = (clear ? 7'd0 : m_vec) | nw;
        m_pulse = (nw != 0);
        if (clear) m_cnt = (nw != 0) ? 1 : 0;
        else if (nw != 0 && m_cnt < 255) m_cnt = m_cnt + 1;
        if (clear) begin
            m_cv = 0; m_ccpu = 0; m_ccode = 0; m_caddr = 0;
        end
        if (!m_cv && nw != 0) begin
            found = 0;
            for (int c = 0; c < 7; c++) begin
                for (int i = 0; i < N; i++) begin
                    if (!found && hit[c][i]) begin
                        found = 1;
                        m_ccode = c;
                        m_ccpu = i;
                        m_caddr = (c == 1 || c == 6) ? '0 : t_addr[i];
                    end
                end
            end
            m_cv = 1;
        end
    endtask

    task automatic step();
        for (int i = 0; i < N; i++) begin
            bif.mbus_cmd_array_i[i*MW +: MW] = t_cmd[i];
            bif.mbus_addr_array_i[i*AW +: AW] = t_addr[i];
            bif.mbus_ack_array_i[i] = t_ack[i];
            bif.cbus_cmd_array_i[i*CW +: CW] = t_ccmd[i];
            bif.cbus_ack_array_i[i] = t_cack[i];
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < N; i++) begin
            t_cmd[i] = 0; t_addr[i] = 0; t_ack[i] = 0;
            t_ccmd[i] = 0; t_cack[i] = 0;
        end
        clear = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 0;
        step();
        rst = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        t_cmd[1] = 7; t_ack[0] = 1; t_ccmd[2] = 6;
        rst = 0;
        step();
        n_cmp++;
        if ({err_vec, err, err_count, pending} !== '0) begin
            n_fail++;
            $display("FAIL reset_flags: got vec=%h e=%b cnt=%0d pend=%b required 0",
                     err_vec, err, err_count, pending);
        end
        n_cmp++;
        if ({err_cpu, err_code, err_addr} !== '0) begin
            n_fail++;
            $display("FAIL reset_capture: got %0d/%0d/%h required 0",
                     err_cpu, err_code, err_addr);
        end
        rst = 1;
        idle_inputs();
        step();
    endtask

    task automatic test_rd_ack();
        do_reset();
        t_cmd[1] = 4; t_addr[1] = 32'h40;
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++;
            if (pending !== 4'b0010) begin
                n_fail++;
                $display("FAIL rd_pending_%0d: got %b required 0010", k, pending);
            end
        end
        t_ack[1] = 1;
        step();
        n_cmp++;
        if (pending !== 4'b0000) begin
            n_fail++;
            $display("FAIL rd_ack_release: got %b required 0000", pending);
        end
        idle_inputs();
        step();
        n_cmp++;
        if (err_vec !== 7'h00 || err_count !== 8'd0) begin
            n_fail++;
            $display("FAIL rd_no_err: got vec=%h cnt=%0d required 0/0",
                     err_vec, err_count);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        t_cmd[2] = 1; t_addr[2] = 32'h200;
        step();
        for (int k = 1; k < TO; k++) begin
            step();
            n_cmp++;
            if (err_vec !== 7'h00 || pending[2] !== 1'b1) begin
                n_fail++;
                $display("FAIL to_early_%0d: got vec=%h pend=%b required 00/1",
                         k, err_vec, pending[2]);
            end
        end
        step();
        n_cmp++;
        if (err_vec !== 7'h08 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL to_fire: got vec=%h e=%b required 08/1", err_vec, err);
        end
        step();
        n_cmp++;
        if (err !== 1'b0 || err_count !== 8'd1) begin
            n_fail++;
            $display("FAIL to_once: got e=%b cnt=%0d required 0/1", err, err_count);
        end
        t_ack[2] = 1;
        step();
        idle_inputs();
        step();
        n_cmp++;
        if (pending !== 4'b0 || err_vec !== 7'h08 || err_count !== 8'd1) begin
            n_fail++;
            $display("FAIL to_late_ack: got pend=%b vec=%h cnt=%0d required 0/08/1",
                     pending, err_vec, err_count);
        end
`ifdef MESI_ISC_MON_CAPTURE_EN
        n_cmp++;
        if (err_cpu !== 3'd2 || err_code !== 3'd3 || err_addr !== 32'h200) begin
            n_fail++;
            $display("FAIL to_capture: got %0d/%0d/%h required 2/3/200",
                     err_cpu, err_code, err_addr);
        end
`endif
    endtask

    task automatic test_wr_collision();
        do_reset();
        t_cmd[0] = 1; t_addr[0] = 32'h100;
        t_cmd[3] = 1; t_addr[3] = 32'h100;
        step();
        n_cmp++;
        if (err_vec !== 7'h20 || err_count !== 8'd1 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_same: got vec=%h cnt=%0d e=%b required 20/1/1",
                     err_vec, err_count, err);
        end
`ifdef MESI_ISC_MON_CAPTURE_EN
        n_cmp++;
        if (err_cpu !== 3'd0 || err_code !== 3'd5 || err_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL wr_capture: got %0d/%0d/%h required 0/5/100",
                     err_cpu, err_code, err_addr);
        end
`endif
        do_reset();
        t_cmd[0] = 1; t_addr[0] = 32'h100;
        t_cmd[3] = 1; t_addr[3] = 32'h104;
        step();
        t_cmd[0] = 0; t_cmd[3] = 0;
        t_ack[0] = 1; t_ack[3] = 1;
        step();
        n_cmp++;
        if (err_vec !== 7'h00 || pending !== 4'b0) begin
            n_fail++;
            $display("FAIL wr_diff: got vec=%h pend=%b required 00/0000",
                     err_vec, pending);
        end
    endtask

    task automatic test_multi_error();
        do_reset();
        t_ccmd[0] = 3; t_ccmd[1] = 4;
        t_cmd[2] = 7; t_addr[2] = 32'h300;
        step();
        n_cmp++;
        if (err_vec !== 7'h41 || err_count !== 8'd1) begin
            n_fail++;
            $display("FAIL multi: got vec=%h cnt=%0d required 41/1",
                     err_vec, err_count);
        end
`ifdef MESI_ISC_MON_CAPTURE_EN
        n_cmp++;
        if (err_cpu !== 3'd2 || err_code !== 3'd0 || err_addr !== 32'h300) begin
            n_fail++;
            $display("FAIL multi_capture: got %0d/%0d/%h required 2/0/300",
                     err_cpu, err_code, err_addr);
        end
`else
        n_cmp++;
        if ({err_cpu, err_code, err_addr} !== '0) begin
            n_fail++;
            $display("FAIL multi_nocap: got %0d/%0d/%h required 0",
                     err_cpu, err_code, err_addr);
        end
`endif
    endtask

    task automatic test_spurious_clear();
        do_reset();
        t_ack[0] = 1;
        step();
        step();
        n_cmp++;
        if (err_vec !== 7'h14 || err_count !== 8'd2) begin
            n_fail++;
            $display("FAIL spur_held: got vec=%h cnt=%0d required 14/2",
                     err_vec, err_count);
        end
        idle_inputs();
        step();
        n_cmp++;
        if (err_vec !== 7'h14 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL spur_sticky: got vec=%h e=%b required 14/0", err_vec, err);
        end
        clear = 1; t_ack[1] = 1; t_addr[1] = 32'h55;
        step();
        n_cmp++;
        if (err_vec !== 7'h10 || err_count !== 8'd1 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_same: got vec=%h cnt=%0d e=%b required 10/1/1",
                     err_vec, err_count, err);
        end
`ifdef MESI_ISC_MON_CAPTURE_EN
        n_cmp++;
        if (err_cpu !== 3'd1 || err_code !== 3'd4 || err_addr !== 32'h55) begin
            n_fail++;
            $display("FAIL clear_capture: got %0d/%0d/%h required 1/4/55",
                     err_cpu, err_code, err_addr);
        end
`endif
        idle_inputs();
    endtask

    task automatic test_saturate_reset();
        do_reset();
        t_cmd[0] = 7;
        for (int k = 1; k <= 300; k++) begin
            step();
            if (k == 100 || k == 255 || k == 300) begin
                n_cmp++;
                if (err_count !== 8'((k > 255) ? 255 : k)) begin
                    n_fail++;
                    $display("FAIL sat_%0d: got %0d required %0d", k, err_count,
                             (k > 255) ? 255 : k);
                end
            end
        end
        t_cmd[0] = 0; t_cmd[1] = 2;
        step();
        n_cmp++;
        if (pending[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_pend1: got %b required 1", pending[1]);
        end
        rst = 0;
        step();
        n_cmp++;
        if ({err_vec, err, err_count, pending, err_cpu, err_code, err_addr} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: got vec=%h cnt=%0d pend=%b cap=%0d/%0d/%h required 0",
                     err_vec, err_count, pending, err_cpu, err_code, err_addr);
        end
        rst = 1;
        idle_inputs();
    endtask

    task automatic test_random();
        logic [AW-1:0] pool [3];
        logic [N-1:0]  exp_pend;
        int r;
        int ackw;
        pool[0] = 32'h100; pool[1] = 32'h104; pool[2] = 32'h40;
        do_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            ackw = (cyc < 700) ? 5 : 25;
            for (int i = 0; i < N; i++) begin
                r = $urandom_range(0, 15);
                if (r < 9) t_cmd[i] = 0;
                else if (r < 14) t_cmd[i] = 3'($urandom_range(1, 4));
                else t_cmd[i] = 3'($urandom_range(5, 7));
                t_addr[i] = pool[$urandom_range(0, 2)];
                t_ack[i] = ($urandom_range(0, ackw) == 0);
                t_ccmd[i] = ($urandom_range(0, 9) < 6) ? 3'd0 :
                            3'($urandom_range(1, 5));
                t_cack[i] = 1'($urandom_range(0, 1));
            end
            clear = ($urandom_range(0, 30) == 0);
            rst = ($urandom_range(0, 200) == 0) ? 1'b0 : 1'b1;
            step();
            for (int i = 0; i < N; i++) exp_pend[i] = (m_age[i] != 0);
            n_cmp++;
            if (err_vec !== m_vec || err !== m_pulse || err_count !== 8'(m_cnt)) begin
                n_fail++;
                $display("FAIL rnd_flags@%0d: got vec=%h e=%b cnt=%0d required %h/%b/%0d",
                         cyc, err_vec, err, err_count, m_vec, m_pulse, m_cnt);
            end
            n_cmp++;
            if (pending !== exp_pend) begin
                n_fail++;
                $display("FAIL rnd_pend@%0d: got %b required %b", cyc, pending, exp_pend);
            end
`ifdef MESI_ISC_MON_CAPTURE_EN
            n_cmp++;
            if (err_cpu !== 3'(m_ccpu) || err_code !== 3'(m_ccode) ||
                err_addr !== m_caddr) begin
                n_fail++;
                $display("FAIL rnd_cap@%0d: got %0d/%0d/%h required %0d/%0d/%h",
                         cyc, err_cpu, err_code, err_addr, m_ccpu, m_ccode, m_caddr);
            end
`endif
        end
        rst = 1;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_rd_ack();
        test_timeout();
        test_wr_collision();
        test_multi_error();
        test_spurious_clear();
        test_saturate_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
